// File: rtl/led_pattern_gen.sv
// led_pattern_gen: multi-channel programmable LED driver.
// Each channel independently runs OFF, ON, free-running BLINK or one-shot pulse
// with its own half-period. Out of reset every channel blinks with DEFAULT_HALF.
//
// Ports:
//   clk          clock
//   rst          synchronous active-high reset, overrides every other input
//   cfg_we_i     configuration write strobe (one write per asserted cycle)
//   cfg_ch_i     channel addressed by the write; indices >= N_CH are ignored
//   cfg_mode_i   0 OFF, 1 ON, 2 BLINK, 3 ONESHOT
//   cfg_half_i   half-period; each high/low phase lasts cfg_half_i+1 cycles
//   sync_i       restarts every BLINK channel in its low phase
//   led_o        registered LED outputs
//   active_o     registered: channel is in BLINK or ONESHOT
module led_pattern_gen #(
  parameter int unsigned N_CH = 4,
  parameter int unsigned CNT_W = 32,
  parameter logic [CNT_W-1:0] DEFAULT_HALF = CNT_W'(99999999),
  localparam int unsigned CH_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we_i,
  input  logic [CH_W-1:0]  cfg_ch_i,
  input  logic [1:0]       cfg_mode_i,
  input  logic [CNT_W-1:0] cfg_half_i,
  input  logic             sync_i,
  output logic [N_CH-1:0]  led_o,
  output logic [N_CH-1:0]  active_o
);

  localparam logic [1:0] ModeOff     = 2'd0;
  localparam logic [1:0] ModeOn      = 2'd1;
  localparam logic [1:0] ModeBlink   = 2'd2;
  localparam logic [1:0] ModeOneshot = 2'd3;

  logic [1:0]       mode_q [N_CH];
  logic [1:0]       mode_d [N_CH];
  logic [CNT_W-1:0] half_q [N_CH];
  logic [CNT_W-1:0] half_d [N_CH];
  logic [CNT_W-1:0] cnt_q  [N_CH];
  logic [CNT_W-1:0] cnt_d  [N_CH];
  logic [N_CH-1:0]  led_q, led_d;
  logic [N_CH-1:0]  active_q, active_d;
  logic [N_CH-1:0]  wr_hit;

  // Out-of-range indices never match any channel, so such writes are dropped.
  always_comb begin
    wr_hit = '0;
    for (int i = 0; i < N_CH; i++) begin
      wr_hit[i] = cfg_we_i && (cfg_ch_i == CH_W'(i));
    end
  end

  always_comb begin
    led_d    = led_q;
    active_d = '0;
    for (int i = 0; i < N_CH; i++) begin
      mode_d[i] = mode_q[i];
      half_d[i] = half_q[i];
      cnt_d[i]  = cnt_q[i];

      case (mode_q[i])
        ModeOff: begin
          cnt_d[i] = '0;
          led_d[i] = 1'b0;
        end
        ModeOn: begin
          cnt_d[i] = '0;
          led_d[i] = 1'b1;
        end
        ModeBlink: begin
          if (cnt_q[i] == half_q[i]) begin
            cnt_d[i] = '0;
            led_d[i] = ~led_q[i];
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
          end
        end
        default: begin // ModeOneshot
          if (cnt_q[i] == half_q[i]) begin
            cnt_d[i]  = '0;
            led_d[i]  = 1'b0;
            mode_d[i] = ModeOff;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
          end
        end
      endcase

      if (sync_i && (mode_q[i] == ModeBlink)) begin
        cnt_d[i] = '0;
        led_d[i] = 1'b0;
      end

      // A write takes priority over sync and over the running mode.
      if (wr_hit[i]) begin
        mode_d[i] = cfg_mode_i;
        half_d[i] = cfg_half_i;
        cnt_d[i]  = '0;
        led_d[i]  = (cfg_mode_i == ModeOn) || (cfg_mode_i == ModeOneshot);
      end

      // BLINK and ONESHOT are exactly the encodings with bit 1 set.
      active_d[i] = mode_d[i][1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_CH; i++) begin
        mode_q[i] <= ModeBlink;
        half_q[i] <= DEFAULT_HALF;
        cnt_q[i]  <= '0;
      end
      led_q    <= '0;
      active_q <= '1;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        mode_q[i] <= mode_d[i];
        half_q[i] <= half_d[i];
        cnt_q[i]  <= cnt_d[i];
      end
      led_q    <= led_d;
      active_q <= active_d;
    end
  end

  assign led_o    = led_q;
  assign active_o = active_q;

endmodule
